// File: rtl/phy_clk_div_if.sv
// Control/status bundle between the PHY clock controller and phy_clk_div.
// The master drives ratio/load/enable; the divider returns ack, active and the divided clock.
interface phy_clk_div_if #(
    parameter int DIV_W = 8
);
    logic [DIV_W-1:0] div_ratio;
    logic             div_load;
    logic             div_en;
    logic             div_ack;
    logic             div_active;
    logic             clk_div_out;

    modport master (
        output div_ratio,
        output div_load,
        output div_en,
        input  div_ack,
        input  div_active,
        input  clk_div_out
    );

    modport slave (
        input  div_ratio,
        input  div_load,
        input  div_en,
        output div_ack,
        output div_active,
        output clk_div_out
    );
endinterface

// File: rtl/phy_clk_div.sv
// Programmable integer clock divider feeding phy_clk_buffer. The divided clock
// comes from a single flop; ratio changes and stops only happen at a period boundary.
module phy_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic         clk_in,
    input  logic         reset_n,
    phy_clk_div_if.slave dif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r,  state_nxt_s;
    logic [DIV_W-1:0] cur_r,    cur_nxt_s;
    logic [DIV_W-1:0] pend_r,   pend_nxt_s;
    logic             pend_v_r, pend_v_nxt_s;
    logic [DIV_W-1:0] cnt_r,    cnt_nxt_s;
    logic             out_r,    out_nxt_s;
    logic             ack_r;
    logic             active_r;
    logic             apply_s;
    logic             boundary_s;
    logic [DIV_W:0]   hi_sum_s;
    logic [DIV_W:0]   hi_s;
    logic [DIV_W:0]   cnt_inc_s;

    // Ratios 0 and 1 cannot produce a clock, so they are promoted to 2 on capture.
    function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] r);
        if (r < DIV_W'(2)) begin
            return DIV_W'(2);
        end else begin
            return r;
        end
    endfunction

    // High-phase length ceil(cur/2) and next count, one bit wider to avoid overflow at the max ratio.
    always_comb begin
        hi_sum_s   = {1'b0, cur_r} + {{DIV_W{1'b0}}, 1'b1};
        hi_s       = {1'b0, hi_sum_s[DIV_W:1]};
        cnt_inc_s  = {1'b0, cnt_r} + {{DIV_W{1'b0}}, 1'b1};
        boundary_s = (cnt_r == (cur_r - DIV_W'(1)));
    end

    // Next-state, counter, ratio bookkeeping and next output level.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        cur_nxt_s    = cur_r;
        pend_nxt_s   = pend_r;
        pend_v_nxt_s = pend_v_r;
        out_nxt_s    = 1'b0;
        apply_s      = 1'b0;

        case (state_r)
            IDLE: begin
                cnt_nxt_s = '0;
                apply_s   = pend_v_r;
                if (dif.div_en) begin
                    state_nxt_s = RUN;
                    out_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    out_nxt_s   = 1'b0;
                end
            end
            RUN: begin
                if (boundary_s) begin
                    cnt_nxt_s = '0;
                    apply_s   = pend_v_r;
                    if (dif.div_en) begin
                        state_nxt_s = RUN;
                        out_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                        out_nxt_s   = 1'b0;
                    end
                end else begin
                    cnt_nxt_s = cnt_inc_s[DIV_W-1:0];
                    out_nxt_s = (cnt_inc_s < hi_s);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
                out_nxt_s   = 1'b0;
            end
        endcase

        if (apply_s) begin
            cur_nxt_s    = pend_r;
            pend_v_nxt_s = 1'b0;
        end else begin
            cur_nxt_s    = cur_nxt_s;
        end

        // A capture on an applying edge refills pend; it waits for the next boundary.
        if (dif.div_load) begin
            pend_nxt_s   = clamp_ratio(dif.div_ratio);
            pend_v_nxt_s = 1'b1;
        end else begin
            pend_nxt_s   = pend_nxt_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            cur_r    <= DIV_W'(2);
            pend_r   <= DIV_W'(2);
            pend_v_r <= 1'b0;
            cnt_r    <= '0;
            out_r    <= 1'b0;
            ack_r    <= 1'b0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cur_r    <= cur_nxt_s;
            pend_r   <= pend_nxt_s;
            pend_v_r <= pend_v_nxt_s;
            cnt_r    <= cnt_nxt_s;
            out_r    <= out_nxt_s;
            ack_r    <= apply_s;
            active_r <= (state_nxt_s == RUN);
        end
    end

    assign dif.clk_div_out = out_r;
    assign dif.div_ack     = ack_r;
    assign dif.div_active  = active_r;

endmodule

// File: doc/phy_clk_div.md
# phy_clk_div

Programmable integer clock divider with a glitch-free start/stop and safe ratio update. It sits directly upstream of `phy_clk_buffer` and produces the divided PHY clock that the buffer drives into the clock tree. The output is a single flop so it has no combinational glitches. Ratio changes and stop requests take effect only at a period boundary, so no runt pulse ever reaches the buffer.

## Interface
Parameters:
- `DIV_W`, default 8: width of the ratio field. Usable ratios are 2..2^DIV_W-1.

Ports:
- `clk_in`  input  1: source clock; all logic is rising-edge.
- `reset_n`  input  1: reset, asynchronous and active-low.
- `div_ratio`  input  DIV_W: requested divide ratio N. Values 0 and 1 are clamped to 2.
- `div_load`  input  1: single-cycle request to capture `div_ratio`.
- `div_en`  input  1: level; run the divider while high.
- `div_ack`  output  1: single-cycle pulse when a captured ratio becomes the active ratio.
- `div_active`  output  1: high while the FSM is in RUN.
- `clk_div_out`  output  1: divided clock, registered; feeds `phy_clk_buffer.clk_in`.

## Operation
- Registers:
  - `cur` (active ratio, DIV_W)
  - `pend` (pending ratio) and `pend_v` (pending valid)
  - `cnt` (DIV_W, counts 0..cur-1)
  - `state` in {IDLE, RUN}
- High phase: HI = ceil(cur/2).
  - `clk_div_out` is high for HI cycles and low for cur-HI cycles.
  - Even N gives 50% duty; odd N gives a high phase one cycle longer.
- Ratio clamp: clamping is applied at capture, so `pend` and `cur` never hold a value below 2.
- `div_load`:
  - Captures the clamped `div_ratio` into `pend` and sets `pend_v`.
  - A new load while `pend_v`=1 overwrites `pend` (last wins); exactly one `div_ack` is issued for the value finally applied.
- IDLE behaviour:
  - `clk_div_out`=0, `cnt`=0.
  - If `pend_v` is set: `cur`<=`pend`, `pend_v` is cleared, and `div_ack` pulses on the next edge.
  - If `div_en`=1: go to RUN, `cnt`<=0, `clk_div_out`<=1. The ratio used is `cur`, including a `pend` being applied on the same edge.
- RUN behaviour:
  - Every edge: `cnt`<=`cnt`+1 and `clk_div_out`<=(`cnt`+1 < HI).
- Period boundary in RUN (`cnt`==`cur`-1):
  - `cnt`<=0.
  - If `pend_v`: load `cur` from `pend`, clear `pend_v`, pulse `div_ack`. HI for the new period is computed from the new `cur`.
  - If `div_en`=1: `clk_div_out`<=1 and stay in RUN.
  - If `div_en`=0: `clk_div_out`<=0 and go to IDLE.
- Stop is deferred: deasserting `div_en` mid-period completes the current full period; the output always ends low.
- Re-asserting `div_en` before the boundary cancels the stop with no visible effect.
- Simultaneous load and boundary: `div_load` in the same cycle as the boundary is not applied at that boundary. The value present in `pend` before the edge is applied, and the new capture waits for the next boundary.
- Reset mid-operation: asynchronous; all state returns to reset values immediately. `clk_div_out` drops to 0 without waiting for the period boundary; this is accepted only under reset.

## Timing
- Reset values:
  - `clk_div_out`=0, `div_active`=0, `div_ack`=0
  - `cnt`=0, `cur`=2, `pend_v`=0, `state`=IDLE
- Start latency: `div_en` high at edge k (IDLE) gives `clk_div_out`=1 and `div_active`=1 after edge k.
- Output period is exactly `cur` `clk_in` cycles, with no missing or extra edges across ratio changes.
- Stop latency: IDLE and `clk_div_out` low occur at the first period boundary after `div_en` is sampled low; `div_active` drops on the same edge.
- `div_ack` is asserted for exactly one cycle, on the edge where `cur` changes.
- Maximum ack latency after `div_load` while running is `cur`+1 cycles.
- `div_en` and `div_ratio` are synchronous to `clk_in`; no internal synchronizers.

## Test plan
- Reset, then `div_en`=1 with default ratio -> `clk_div_out` toggles every cycle (period 2); `div_active`=1 one edge after `div_en`.
- `div_load` with ratio 5 while IDLE, then enable -> `div_ack` pulses one cycle; output repeats 3 high, 2 low.
- Running at N=4, load N=7 at `cnt`=1 -> current period finishes as 2 high / 2 low; next periods are 4 high / 3 low; a single `div_ack` at the boundary.
- Running at N=6, drop `div_en` at `cnt`=2 -> output completes the 3 low cycles, then stays 0; `div_active` falls at the boundary. Re-raising `div_en` at `cnt`=4 instead gives an uninterrupted clock.
- `div_load` of 0 and of 1 -> applied ratio is 2. Two back-to-back loads (9 then 3) -> only 3 applied, one ack. A load coinciding with the boundary is applied one period later.
- `reset_n` asserted mid-high-phase at N=8 -> all outputs 0 immediately. After release, `cur`=2, IDLE, no `div_ack`.
